// File: rtl/machine_sequencer_if.sv
// Step sequencer bundle: run control, pattern setup,
// machine strobe/return and capture status.
interface machine_sequencer_if #(
  parameter int DIV_W = 16
);
  logic             start;
  logic             abort;
  logic             mode;
  logic             step_btn;
  logic [7:0]       pattern;
  logic [3:0]       len;
  logic [DIV_W-1:0] div;
  logic             m_out;
  logic             pulse;
  logic             seq_in;
  logic [7:0]       result;
  logic [3:0]       step_cnt;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, mode, step_btn,
    output pattern, len, div, m_out,
    input  pulse, seq_in, result,
    input  step_cnt, busy, done
  );

  modport slave (
    input  start, abort, mode, step_btn,
    input  pattern, len, div, m_out,
    output pulse, seq_in, result,
    output step_cnt, busy, done
  );
endinterface

// File: rtl/machine_sequencer.sv
// Steps an external machine through a bit pattern
// and shifts its registered output into result.
module machine_sequencer #(
  parameter int DIV_W = 16
) (
  input logic                clk,
  input logic                reset,
  machine_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [7:0]       shreg;
  logic [3:0]       len_q;
  logic [3:0]       issued;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] presc;
  logic             btn_q;
  logic             cap;
  logic             done_q;
  logic [7:0]       res_q;
  logic [3:0]       cnt_q;
  logic [3:0]       len_c;
  logic             tick;
  logic             edge_p;
  logic             capt;
  logic             go;
  logic             fin;
  logic             pulse_c;
  logic             busy_c;

  assign len_c  = (bus.len > 4'd8) ? 4'd8 : bus.len;
  assign tick   = (presc == div_q);
  assign edge_p = bus.step_btn & ~btn_q;
  assign capt   = cap & ~bus.abort & (state != IDLE);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state, step strobe and busy decode
  always_comb begin
    state_nx = state;
    pulse_c  = 1'b0;
    busy_c   = 1'b0;
    go       = 1'b0;
    fin      = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          go       = 1'b1;
          state_nx = (len_c == 4'd0) ? IDLE : RUN;
        end
      end
      RUN: begin
        busy_c = 1'b1;
        if (bus.abort) begin
          state_nx = IDLE;
        end else begin
          pulse_c = (issued != len_q) &&
                    (bus.mode ? edge_p : tick);
          if (pulse_c && (issued + 4'd1 == len_q))
            state_nx = DRAIN;
        end
      end
      DRAIN: begin
        busy_c = 1'b1;
        if (bus.abort) begin
          state_nx = IDLE;
        end else if (cap) begin
          state_nx = IDLE;
          fin      = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Pattern shift, prescaler, edge detect and capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg  <= '0;
      len_q  <= '0;
      issued <= '0;
      div_q  <= '0;
      presc  <= '0;
      btn_q  <= 1'b0;
      cap    <= 1'b0;
      done_q <= 1'b0;
      res_q  <= '0;
      cnt_q  <= '0;
    end else begin
      btn_q <= go ? 1'b0 : bus.step_btn;
      cap   <= pulse_c;
      if (go) begin
        shreg  <= bus.pattern;
        len_q  <= len_c;
        div_q  <= bus.div;
        issued <= '0;
        presc  <= '0;
        res_q  <= '0;
        cnt_q  <= '0;
        done_q <= (len_c == 4'd0);
      end else begin
        if (pulse_c) begin
          shreg  <= shreg >> 1;
          issued <= issued + 4'd1;
        end
        if (state == RUN && !bus.mode && !bus.abort)
          presc <= tick ? '0 : presc + DIV_W'(1);
        else
          presc <= '0;
        if (capt) begin
          res_q <= {res_q[6:0], bus.m_out};
          cnt_q <= cnt_q + 4'd1;
        end
        if (fin) done_q <= 1'b1;
      end
    end
  end

  assign bus.pulse    = pulse_c;
  assign bus.seq_in   = shreg[0];
  assign bus.result   = res_q;
  assign bus.step_cnt = cnt_q;
  assign bus.busy     = busy_c;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_machine_sequencer.sv
// Randomized bench: a toggle machine is stepped and
// captures are compared with a per-run step model.
module tb_machine_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   pq[$];
  logic mach;
  logic model_m = 1'b0;

  machine_sequencer_if #(.DIV_W(16)) bi();

  machine_sequencer #(.DIV_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bi.slave)
  );

  always #5 clk = ~clk;

  // toggle machine: flips when stepped with a 1
  always @(posedge clk or negedge reset) begin
    if (!reset)        mach <= 1'b0;
    else if (bi.pulse) mach <= mach ^ bi.seq_in;
  end
  assign bi.m_out = mach;

  // pulse log, sampled mid-cycle
  always @(negedge clk) begin
    if (reset && bi.pulse) pq.push_back(cyc);
    cyc <= cyc + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // n steps of a toggle machine starting at m0:
  // returns {final machine, captured result}
  function automatic logic [8:0] model_run(
    input logic [7:0] p, input int n, input logic m0);
    logic [7:0] r;
    logic       m;
    r = 8'h00;
    m = m0;
    for (int i = 0; i < n; i++) begin
      m = m ^ p[i];
      r = {r[6:0], m};
    end
    return {m, r};
  endfunction

  function automatic int clampl(input logic [3:0] l);
    return (l > 4'd8) ? 8 : int'(l);
  endfunction

  task automatic run_auto(input logic [7:0] p,
                          input logic [3:0] l,
                          input logic [15:0] d);
    int n;
    int c1;
    int per;
    logic [8:0] mr;
    n   = clampl(l);
    per = int'(d) + 1;
    mr  = model_run(p, n, model_m);
    bi.mode = 1'b0;
    bi.pattern = p;
    bi.len = l;
    bi.div = d;
    bi.start = 1'b1;
    pq.delete();
    tick_n(1);
    bi.start = 1'b0;
    bi.pattern = 8'($urandom);
    bi.len = 4'($urandom);
    c1 = cyc;
    if (n == 0) begin
      chk("len0_done", bi.done, 1);
      chk("len0_busy", bi.busy, 0);
      tick_n(4);
      chk("len0_npulse", pq.size(), 0);
      chk("len0_cnt", bi.step_cnt, 0);
      return;
    end
    tick_n(n * per);
    chk("drain_busy", bi.busy, 1);
    chk("drain_done", bi.done, 0);
    tick_n(1);
    chk("end_busy", bi.busy, 0);
    chk("end_done", bi.done, 1);
    chk("result", bi.result, mr[7:0]);
    chk("step_cnt", bi.step_cnt, n);
    chk("npulse", pq.size(), n);
    for (int k = 0; k < n && k < pq.size(); k++)
      chk("ptime", pq[k] - c1, (k + 1) * per - 1);
    model_m = mr[8];
  endtask

  task automatic press();
    bi.step_btn = 1'b0;
    tick_n(2);
    bi.step_btn = 1'b1;
    tick_n(3);
  endtask

  task automatic run_manual(input logic [7:0] p,
                            input logic [3:0] l);
    int n;
    logic [8:0] mr;
    n  = clampl(l);
    mr = model_run(p, n, model_m);
    bi.mode = 1'b1;
    bi.step_btn = 1'b0;
    bi.pattern = p;
    bi.len = l;
    bi.start = 1'b1;
    pq.delete();
    tick_n(1);
    bi.start = 1'b0;
    for (int k = 0; k < n; k++) press();
    chk("man_npulse", pq.size(), n);
    chk("man_done", bi.done, 1);
    chk("man_busy", bi.busy, 0);
    chk("man_result", bi.result, mr[7:0]);
    chk("man_cnt", bi.step_cnt, n);
    bi.step_btn = 1'b0;
    model_m = mr[8];
  endtask

  initial begin
    logic [7:0] p;
    logic [8:0] mr;
    bi.start = 1'b0;
    bi.abort = 1'b0;
    bi.mode = 1'b0;
    bi.step_btn = 1'b0;
    bi.pattern = 8'h00;
    bi.len = 4'd0;
    bi.div = 16'd0;
    #12;
    chk("rst_pulse", bi.pulse, 0);
    chk("rst_busy", bi.busy, 0);
    chk("rst_done", bi.done, 0);
    chk("rst_result", bi.result, 0);
    chk("rst_cnt", bi.step_cnt, 0);
    chk("rst_seq_in", bi.seq_in, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick_n(2);

    run_auto(8'hFF, 4'd4, 16'd0);
    chk("ff_result_0a", bi.result, 8'h0A);
    run_auto(8'($urandom), 4'd2, 16'd3);
    run_manual(8'($urandom), 4'd3);
    run_auto(8'($urandom), 4'd0, 16'd2);
    run_auto(8'($urandom), 4'd12, 16'd1);

    // abort after 2 of 5 manual steps
    p = 8'($urandom);
    mr = model_run(p, 2, model_m);
    bi.mode = 1'b1;
    bi.pattern = p;
    bi.len = 4'd5;
    bi.start = 1'b1;
    pq.delete();
    tick_n(1);
    bi.start = 1'b0;
    press();
    press();
    bi.abort = 1'b1;
    tick_n(1);
    bi.abort = 1'b0;
    chk("abt_busy", bi.busy, 0);
    chk("abt_done", bi.done, 0);
    chk("abt_cnt", bi.step_cnt, 2);
    chk("abt_result", bi.result, mr[7:0]);
    model_m = mr[8];
    press();
    chk("abt_npulse", pq.size(), 2);
    bi.step_btn = 1'b0;

    // start and abort together in IDLE
    p = 8'($urandom);
    mr = model_run(p, 2, model_m);
    bi.mode = 1'b0;
    bi.div = 16'd0;
    bi.pattern = p;
    bi.len = 4'd2;
    bi.start = 1'b1;
    bi.abort = 1'b1;
    tick_n(1);
    bi.start = 1'b0;
    bi.abort = 1'b0;
    chk("sa_busy", bi.busy, 1);
    tick_n(3);
    chk("sa_done", bi.done, 1);
    chk("sa_result", bi.result, mr[7:0]);
    model_m = mr[8];

    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 1) == 0)
        run_auto(8'($urandom),
                 4'($urandom_range(0, 15)),
                 16'($urandom_range(0, 3)));
      else
        run_manual(8'($urandom),
                   4'($urandom_range(1, 15)));
    end

    // reset between edges in mid-run
    bi.mode = 1'b0;
    bi.div = 16'd3;
    bi.len = 4'd8;
    bi.pattern = 8'($urandom);
    bi.start = 1'b1;
    tick_n(1);
    bi.start = 1'b0;
    tick_n(5);
    #3;
    reset = 1'b0;
    #1;
    chk("mr_pulse", bi.pulse, 0);
    chk("mr_seq_in", bi.seq_in, 0);
    chk("mr_result", bi.result, 0);
    chk("mr_cnt", bi.step_cnt, 0);
    chk("mr_busy", bi.busy, 0);
    chk("mr_done", bi.done, 0);
    model_m = 1'b0;
    tick_n(2);
    reset = 1'b1;
    pq.delete();
    tick_n(20);
    chk("mr_npulse", pq.size(), 0);
    chk("mr_idle", bi.busy, 0);

    run_auto(8'($urandom), 4'd3, 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
